// File: rtl/proc_ctrl.sv
// proc_ctrl: control unit for the 4-register, 6-bit processor datapath.
//
// Fetches a 6-bit instruction {op[1:0], X[1:0], Y[1:0]} from DIN when Run is
// sampled high in T0, then sequences the busmux selects and the register,
// accumulator and ALU enables over 1 (mv/mvi) or 3 (add/sub) execute cycles.
// Done is high on the last execute cycle.
//
// Ports:
//   Clock   in   rising-edge clock
//   Resetn  in   asynchronous active-low reset
//   Run     in   start request, sampled only in T0
//   DIN     in   instruction word in T0 (immediate for mvi in T1)
//   Rout    out  one-hot bus source select, bit 3 = R0 .. bit 0 = R3
//   Gout    out  G drives the bus
//   DINout  out  DIN drives the bus
//   Rin     out  one-hot register load enable, same ordering as Rout
//   Ain     out  load A from the bus
//   Gin     out  load G with the ALU result
//   AddSub  out  0 = A+bus, 1 = A-bus (meaningful only with Gin)
//   Done    out  one-cycle pulse on the final cycle of each instruction
module proc_ctrl #(
  parameter int REG_NUM   = 4,
  parameter int DATAWIDTH = 6
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Run,
  input  logic [DATAWIDTH-1:0] DIN,
  output logic [REG_NUM-1:0]   Rout,
  output logic                 Gout,
  output logic                 DINout,
  output logic [REG_NUM-1:0]   Rin,
  output logic                 Ain,
  output logic                 Gin,
  output logic                 AddSub,
  output logic                 Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_NUM-1:0] rout;
    logic               gout;
    logic               dinout;
    logic [REG_NUM-1:0] rin;
    logic               ain;
    logic               gin;
    logic               addsub;
    logic               done;
  } ctrl_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] ir_q, ir_d;
  ctrl_t                ctrl_q;

  // One-hot register select in busmux ordering: index 0 maps to the MSB.
  function automatic logic [REG_NUM-1:0] sel(input logic [1:0] n);
    logic [REG_NUM-1:0] msb;
    msb = {1'b1, {(REG_NUM-1){1'b0}}};
    return msb >> n;
  endfunction

  // Moore output decode for a given state and instruction word.
  function automatic ctrl_t decode(input state_t st, input logic [DATAWIDTH-1:0] ir);
    ctrl_t      c;
    logic [1:0] op;
    logic [1:0] x;
    logic [1:0] y;
    c  = '0;
    op = ir[5:4];
    x  = ir[3:2];
    y  = ir[1:0];
    case (st)
      T0: c = '0;
      T1: begin
        case (op)
          2'b00: begin
            c.rout = sel(y);
            c.rin  = sel(x);
            c.done = 1'b1;
          end
          2'b01: begin
            c.dinout = 1'b1;
            c.rin    = sel(x);
            c.done   = 1'b1;
          end
          default: begin
            c.rout = sel(x);
            c.ain  = 1'b1;
          end
        endcase
      end
      T2: begin
        c.rout   = sel(y);
        c.gin    = 1'b1;
        c.addsub = op[0];
      end
      T3: begin
        c.gout = 1'b1;
        c.rin  = sel(x);
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state and instruction-register update; Run is only looked at in T0.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        if (Run) begin
          ir_d    = DIN;
          state_d = T1;
        end else begin
          state_d = T0;
        end
      end
      // op[1] set means add/sub, which needs the two extra cycles
      T1: begin
        if (ir_q[5]) begin
          state_d = T2;
        end else begin
          state_d = T0;
        end
      end
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // State, IR and registered outputs; outputs are decoded from the next
  // state so they always equal decode(state_q, ir_q) without a cycle lag.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= decode(state_d, ir_d);
    end
  end

  assign Rout   = ctrl_q.rout;
  assign Gout   = ctrl_q.gout;
  assign DINout = ctrl_q.dinout;
  assign Rin    = ctrl_q.rin;
  assign Ain    = ctrl_q.ain;
  assign Gin    = ctrl_q.gin;
  assign AddSub = ctrl_q.addsub;
  assign Done   = ctrl_q.done;

endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: scoreboard bench for proc_ctrl. Stimulus pushes the expected
// per-cycle control vectors when an instruction is fetched; a monitor pops
// and compares whenever the controller drives anything. A small datapath
// model (R0..R3, A, G, busmux) confirms the resulting register contents.
module tb_proc_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run;
  logic [5:0] DIN;
  logic [3:0] Rout;
  logic       Gout;
  logic       DINout;
  logic [3:0] Rin;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;

  int n_pass  = 0;
  int n_total = 0;
  int n_fetch = 0;
  int n_done  = 0;
  int cyc     = 0;
  int c0;

  logic [14:0] exp_q[$];
  int          done_cyc[$];

  logic [5:0] R[4];
  logic [5:0] A;
  logic [5:0] G;
  logic [5:0] bus;

  proc_ctrl #(.REG_NUM(4), .DATAWIDTH(6)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Run   (Run),
    .DIN   (DIN),
    .Rout  (Rout),
    .Gout  (Gout),
    .DINout(DINout),
    .Rin   (Rin),
    .Ain   (Ain),
    .Gin   (Gin),
    .AddSub(AddSub),
    .Done  (Done)
  );

  always #5 Clock = ~Clock;

  // cycle counter
  always @(posedge Clock) cyc <= cyc + 1;

  // busmux model
  always_comb begin
    bus = DIN;
    if (DINout)       bus = DIN;
    else if (Gout)    bus = G;
    else if (Rout[3]) bus = R[0];
    else if (Rout[2]) bus = R[1];
    else if (Rout[1]) bus = R[2];
    else if (Rout[0]) bus = R[3];
    else              bus = DIN;
  end

  // register file, A and G model
  always @(posedge Clock) begin
    for (int i = 0; i < 4; i++) if (Rin[3-i]) R[i] <= bus;
    if (Ain) A <= bus;
    if (Gin) G <= AddSub ? (A - bus) : (A + bus);
  end

  function automatic logic [14:0] cur_out();
    return {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done};
  endfunction

  function automatic logic [3:0] sel(input logic [1:0] n);
    logic [3:0] m;
    m = 4'b1000;
    return m >> n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    else n_pass++;
  endtask

  // expected vectors {Rout,Gout,DINout,Rin,Ain,Gin,AddSub,Done} per execute cycle
  task automatic push_exp(input logic [5:0] ir);
    logic [1:0] op, x, y;
    op = ir[5:4]; x = ir[3:2]; y = ir[1:0];
    case (op)
      2'b00: exp_q.push_back({sel(y), 1'b0, 1'b0, sel(x), 1'b0, 1'b0, 1'b0, 1'b1});
      2'b01: exp_q.push_back({4'b0000, 1'b0, 1'b1, sel(x), 1'b0, 1'b0, 1'b0, 1'b1});
      default: begin
        exp_q.push_back({sel(x), 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({sel(y), 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, op[0], 1'b0});
        exp_q.push_back({4'b0000, 1'b1, 1'b0, sel(x), 1'b0, 1'b0, 1'b0, 1'b1});
      end
    endcase
  endtask

  // Called at a negedge in T0; returns at the negedge of the next T0.
  // run_mode during execute: 0 = Run low, 1 = Run held high, 2 = random.
  task automatic issue(input logic [5:0] ir, input logic [5:0] imm, input int run_mode);
    int n;
    n = ir[5] ? 3 : 1;
    Run = 1'b1;
    DIN = ir;
    push_exp(ir);
    n_fetch++;
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      DIN = (ir[5:4] == 2'b01) ? imm : 6'($urandom);
      case (run_mode)
        0:       Run = 1'b0;
        1:       Run = 1'b1;
        default: Run = 1'($urandom);
      endcase
    end
    @(negedge Clock);
    Run = 1'b0;
  endtask

  task automatic idle(input int n);
    Run = 1'b0;
    repeat (n) @(negedge Clock);
  endtask

  // monitor: exclusivity every cycle, scoreboard compare whenever outputs are active
  always @(negedge Clock) begin
    logic [14:0] act;
    if (Resetn === 1'b1) begin
      act = cur_out();
      chk("bus_excl", 32'(($countones(Rout) + int'(Gout) + int'(DINout)) <= 1), 32'd1);
      if (Done) begin
        n_done++;
        done_cyc.push_back(cyc);
      end
      if (act != 15'd0) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'(act), 32'd0);
        else chk("exec_vec", 32'(act), 32'(exp_q.pop_front()));
      end else if (exp_q.size() == 0) begin
        chk("idle_zero", 32'(act), 32'd0);
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 6'd0;
    #1;
    chk("reset_out", 32'(cur_out()), 32'd0);
    repeat (2) @(negedge Clock);
    #2 Resetn = 1'b1;
    idle(2);

    // add R0,R1 aborted by reset in the middle of T2
    Run = 1'b1;
    DIN = 6'b10_00_01;
    push_exp(DIN);
    @(negedge Clock);
    Run = 1'b0;
    @(negedge Clock);
    #2 Resetn = 1'b0;
    exp_q.delete();
    #1 chk("reset_abort_out", 32'(cur_out()), 32'd0);
    @(negedge Clock);
    chk("reset_hold_out", 32'(cur_out()), 32'd0);
    #2 Resetn = 1'b1;
    idle(3);

    // mvi R2,#0x2A
    issue(6'b01_10_00, 6'h2A, 0);
    chk("R2_mvi", 32'(R[2]), 32'h2A);

    // mvi R3,#0x15 ; mv R0,R3
    issue(6'b01_11_00, 6'h15, 0);
    issue(6'b00_00_11, 6'h00, 0);
    chk("R0_mv", 32'(R[0]), 32'h15);

    // R1=9, R2=4 ; sub R1,R2 -> 5
    issue(6'b01_01_00, 6'd9, 0);
    issue(6'b01_10_00, 6'd4, 0);
    issue(6'b11_01_10, 6'h00, 0);
    chk("R1_sub", 32'(R[1]), 32'd5);

    // back-to-back: add R0,R1 then mv R3,R0 with Run held
    c0 = cyc;
    issue(6'b10_00_01, 6'h00, 1);
    issue(6'b00_11_00, 6'h00, 1);
    chk("b2b_done_add", 32'(done_cyc[done_cyc.size()-2]), 32'(c0 + 3));
    chk("b2b_done_mv", 32'(done_cyc[done_cyc.size()-1]), 32'(c0 + 5));
    chk("R0_add", 32'(R[0]), 32'h1A);
    chk("R3_mv", 32'(R[3]), 32'h1A);

    // Run toggled during execute: add R2,R2 self-add (4+4)
    issue(6'b10_10_10, 6'h00, 2);
    chk("R2_selfadd", 32'(R[2]), 32'd8);
    idle(1);

    // random instruction stream with random Run during execute and idle gaps
    for (int i = 0; i < 24; i++) begin
      issue(6'($urandom), 6'($urandom), 2);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_per_fetch", 32'(n_done), 32'(n_fetch));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
